// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks req/gnt/rvalid to imem,
// and holds the IF/ID register with a one-entry skid buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_FULL = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] skid_q, skid_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] idpc_q, idpc_d;
  logic [31:0] idp4_q, idp4_d;

  logic        accept;
  logic        load;
  logic [31:0] load_instr;
  logic [31:0] tgt_pc;

  assign accept = ~valid_q | ~stall;
  assign tgt_pc = redirect_pc & ~32'd3;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    skid_d     = skid_q;
    load       = 1'b0;
    load_instr = imem_rdata;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = redirect ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            state_d = S_REQ;
          end else if (accept) begin
            load    = 1'b1;
            state_d = S_REQ;
          end else begin
            skid_d  = imem_rdata;
            state_d = S_FULL;
          end
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      S_FULL: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = skid_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) pc_d = tgt_pc;
  end

  // Redirect outranks any load; a bare ~stall drains the slot.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    idpc_d  = idpc_q;
    idp4_d  = idp4_q;
    if (redirect) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      idpc_d  = req_pc_q;
      idp4_d  = req_pc_q + 32'd4;
    end else if (!stall) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC & ~32'd3;
      req_pc_q <= '0;
      skid_q   <= '0;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      idpc_q   <= '0;
      idp4_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      skid_q   <= skid_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      idpc_q   <= idpc_d;
      idp4_q   <= idp4_d;
    end
  end

  assign imem_req       = (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign id_valid       = valid_q;
  assign id_instruction = instr_q;
  assign id_pc          = idpc_q;
  assign id_pc_plus4    = idp4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner
// sequences, then random traffic against a fetch-stream reference model.
module tb_fetch_stage;

  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instruction(id_instruction),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        g, rv, st;
    logic [31:0] rd;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] ei, epc, ep4;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(
    input logic g, rv, st, input logic [31:0] rd,
    input logic ereq, input logic [31:0] eaddr,
    input logic ev, input logic [31:0] ei, epc, ep4);
    vec_t v;
    v.g = g; v.rv = rv; v.st = st; v.rd = rd;
    v.ereq = ereq; v.eaddr = eaddr; v.ev = ev;
    v.ei = ei; v.epc = epc; v.ep4 = ep4;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic expect_out(input string nm,
    input logic ereq, input logic [31:0] eaddr,
    input logic ev, input logic [31:0] ei, epc, ep4);
    chk({nm, ".req"}, {31'd0, imem_req}, {31'd0, ereq});
    chk({nm, ".addr"}, imem_addr, eaddr);
    chk({nm, ".valid"}, {31'd0, id_valid}, {31'd0, ev});
    chk({nm, ".instr"}, id_instruction, ei);
    chk({nm, ".pc"}, id_pc, epc);
    chk({nm, ".pc4"}, id_pc_plus4, ep4);
  endtask

  task automatic drive(input logic g, rv, input logic [31:0] rd,
                       input logic st, rdr, input logic [31:0] rpc);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    stall       = st;
    redirect    = rdr;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // reference-model state for the random phase
  logic [31:0] exp_req, exp_cons, o_addr, rpc_r, rdat_r;
  logic        outst, prev_hold, r_r, g_r, rv_r, st_r, rdr_r;
  logic        h_v;
  logic [31:0] h_i, h_pc, h_p4;
  int          age, dly, n_cons;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1,0,0,0,        0,0,   0,NOP,0,0);
    tbl[1]  = mk(1,0,0,0,        1,0,   0,NOP,0,0);
    tbl[2]  = mk(1,1,0,0^K,      0,4,   0,NOP,0,0);
    tbl[3]  = mk(1,0,0,0,        1,4,   1,0^K,0,4);
    tbl[4]  = mk(1,1,0,4^K,      0,8,   0,0^K,0,4);
    tbl[5]  = mk(1,0,1,0,        1,8,   1,4^K,4,8);
    tbl[6]  = mk(1,1,1,8^K,      0,12,  1,4^K,4,8);
    tbl[7]  = mk(1,0,1,0,        0,12,  1,4^K,4,8);
    tbl[8]  = mk(1,0,1,0,        0,12,  1,4^K,4,8);
    tbl[9]  = mk(1,0,1,0,        0,12,  1,4^K,4,8);
    tbl[10] = mk(1,0,0,0,        0,12,  1,4^K,4,8);
    tbl[11] = mk(1,0,0,0,        1,12,  1,8^K,8,12);
    tbl[12] = mk(1,1,0,12^K,     0,16,  0,8^K,8,12);
    tbl[13] = mk(0,0,0,0,        1,16,  1,12^K,12,16);

    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0, NOP, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].g, tbl[i].rv, tbl[i].rd, tbl[i].st, 0, 0);
      expect_out($sformatf("row%0d", i), tbl[i].ereq, tbl[i].eaddr,
                 tbl[i].ev, tbl[i].ei, tbl[i].epc, tbl[i].ep4);
      tick;
    end

    // redirect while waiting; stale response arrives 3 cycles later
    drive(1,0,0,0,0,0); tick;
    expect_out("rw_wait", 0, 20, 0, 12^K, 12, 16);
    drive(0,0,0,0,1,32'h103); tick;
    expect_out("rw_drop0", 0, 32'h100, 0, NOP, 12, 16);
    drive(0,0,0,0,0,0); tick;
    expect_out("rw_drop1", 0, 32'h100, 0, NOP, 12, 16);
    drive(0,0,0,0,0,0); tick;
    expect_out("rw_drop2", 0, 32'h100, 0, NOP, 12, 16);
    drive(0,1,16^K,0,0,0); tick;
    expect_out("rw_refetch", 1, 32'h100, 0, NOP, 12, 16);
    drive(1,0,0,0,0,0); tick;
    expect_out("rw_wait2", 0, 32'h104, 0, NOP, 12, 16);
    drive(0,1,32'h100^K,0,0,0); tick;
    expect_out("rw_load", 1, 32'h104, 1, 32'h100^K, 32'h100, 32'h104);

    // redirect together with gnt while stalled
    drive(1,0,0,1,1,32'h200); tick;
    expect_out("rg_flush", 0, 32'h200, 0, NOP, 32'h100, 32'h104);
    drive(0,1,32'h104^K,0,0,0); tick;
    expect_out("rg_req", 1, 32'h200, 0, NOP, 32'h100, 32'h104);
    drive(1,0,0,0,0,0); tick;
    expect_out("rg_wait", 0, 32'h204, 0, NOP, 32'h100, 32'h104);
    drive(0,1,32'h200^K,0,0,0); tick;
    expect_out("rg_load", 1, 32'h204, 1, 32'h200^K, 32'h200, 32'h204);

    // PC wrap at the top of the address space
    drive(0,0,0,0,1,32'hFFFF_FFFC); tick;
    expect_out("wr_req", 1, 32'hFFFF_FFFC, 0, NOP, 32'h200, 32'h204);
    drive(1,0,0,0,0,0); tick;
    expect_out("wr_wait", 0, 0, 0, NOP, 32'h200, 32'h204);
    drive(0,1,32'hFFFF_FFFC^K,0,0,0); tick;
    expect_out("wr_load", 1, 0, 1, 32'hFFFF_FFFC^K, 32'hFFFF_FFFC, 0);
    drive(1,0,0,0,0,0); tick;
    expect_out("wr_wait2", 0, 4, 0, 32'hFFFF_FFFC^K, 32'hFFFF_FFFC, 0);
    drive(0,1,0^K,0,0,0); tick;
    expect_out("wr_load2", 1, 4, 1, 0^K, 0, 4);

    // async reset in the middle of a transaction
    drive(1,0,0,0,0,0); tick;
    expect_out("rs_wait", 0, 8, 0, 0^K, 0, 4);
    drive(0,0,0,0,0,0);
    #2 rst_n = 1'b0;
    #1 expect_out("rs_async", 0, 0, 0, NOP, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,1,32'hDEAD_BEEF,0,0,0); tick;
    expect_out("rs_req", 1, 0, 0, NOP, 0, 0);
    drive(0,1,32'hDEAD_BEEF,0,0,0); tick;
    expect_out("rs_ignore", 1, 0, 0, NOP, 0, 0);
    drive(1,0,0,0,0,0); tick;
    expect_out("rs_wait2", 0, 4, 0, NOP, 0, 0);
    drive(0,1,0^K,0,0,0); tick;
    expect_out("rs_load", 1, 4, 1, 0^K, 0, 4);

    // random traffic: the consumed stream must be contiguous from the
    // last redirect target, with each word matching its address
    drive(0,0,0,0,0,0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    exp_req = 0; exp_cons = 0; outst = 0; prev_hold = 0;
    age = 0; dly = 1; n_cons = 0; o_addr = 0;
    h_v = 0; h_i = 0; h_pc = 0; h_p4 = 0;
    for (int c = 0; c < 3000; c++) begin
      r_r = imem_req;
      if (r_r) chk("one_outstanding", {31'd0, outst}, 0);
      st_r  = ($urandom_range(0, 3) == 0);
      rdr_r = ($urandom_range(0, 15) == 0);
      rpc_r = ($urandom_range(0, 3) == 0)
            ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      g_r   = r_r && ($urandom_range(0, 2) != 0);
      rv_r  = outst && (age >= dly);
      rdat_r = rv_r ? (o_addr ^ K) : $urandom;
      drive(g_r, rv_r, rdat_r, st_r, rdr_r, rpc_r);
      if (prev_hold) begin
        chk("hold_valid", {31'd0, id_valid}, {31'd0, h_v});
        chk("hold_instr", id_instruction, h_i);
        chk("hold_pc", id_pc, h_pc);
        chk("hold_pc4", id_pc_plus4, h_p4);
      end
      if (id_valid && !st_r && !rdr_r) begin
        chk("cons_pc", id_pc, exp_cons);
        chk("cons_instr", id_instruction, id_pc ^ K);
        chk("cons_pc4", id_pc_plus4, id_pc + 32'd4);
        exp_cons = exp_cons + 32'd4;
        n_cons++;
      end
      prev_hold = id_valid && st_r && !rdr_r;
      h_v = id_valid; h_i = id_instruction;
      h_pc = id_pc; h_p4 = id_pc_plus4;
      if (rv_r) outst = 1'b0;
      if (r_r && g_r) begin
        chk("req_addr", imem_addr, exp_req);
        exp_req = exp_req + 32'd4;
        outst = 1'b1;
        o_addr = imem_addr;
        age = 0;
        dly = $urandom_range(1, 3);
      end
      if (rdr_r) begin
        exp_req  = rpc_r & ~32'd3;
        exp_cons = rpc_r & ~32'd3;
      end
      tick;
      age++;
    end
    chk("progress", {31'd0, n_cons > 100}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
